// File: rtl/fu_gst_dec19.sv
// ---------------------------------------------------------------------------
// fu_gst_dec19 -- multi-cycle 19-bit decrementer.
//
// Takes an operand in_a and a step count in_k (0..7). It subtracts one per
// BUSY cycle and presents in_a - in_k with a borrow flag and a zero flag.
// Vectors are numbered [1:19] with bit 1 the MSB; in_k is [0:2] with bit 0
// the MSB.
//
// Handshake: a transfer happens on a rising nclk edge where valid and ready
// are both 1. The input side is ready only in IDLE and the output side is
// valid only in DONE, so an operand is never accepted in the same cycle a
// result leaves. in_val with in_rdy=0 is legal and captures nothing.
//
// Ports:
//   nclk      clock, rising edge
//   rst_b     asynchronous active-low reset
//   flush     synchronous abort; drops any operation in progress
//   in_val    operand valid           in_rdy   block can accept an operand
//   in_a      operand [1:19]          in_k     decrement steps [0:2]
//   out_val   result valid            out_rdy  consumer accepts result
//   out_o     result [1:19]           out_brw  a step was taken with acc=0
//   out_zero  out_o == 0
//   dbg_state FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Build option: define FU_GST_DEC19_SAT_EN to saturate at zero instead of
// wrapping to 0x7FFFF when a step is taken with the accumulator at zero.
// ---------------------------------------------------------------------------
module fu_gst_dec19 (
    input  logic        nclk,
    input  logic        rst_b,
    input  logic        flush,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [1:19] in_a,
    input  logic [0:2]  in_k,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [1:19] out_o,
    output logic        out_brw,
    output logic        out_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [1:19] acc, acc_n;
    logic [0:2]  cnt, cnt_n;
    logic        brw, brw_n;
    logic        acc_is_zero;
    logic [1:19] acc_step;

    assign acc_is_zero = (acc == 19'd0);

    // Value of one BUSY step; only the acc==0 case differs between builds.
`ifdef FU_GST_DEC19_SAT_EN
    assign acc_step = acc_is_zero ? 19'd0 : acc - 19'd1;
`else
    assign acc_step = acc - 19'd1;
`endif

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            acc   <= 19'd0;
            cnt   <= 3'd0;
            brw   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            brw   <= brw_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        brw_n   = brw;

        unique case (state)
            IDLE: begin
                if (in_val) begin
                    acc_n   = in_a;
                    cnt_n   = in_k;
                    brw_n   = 1'b0;
                    state_n = (in_k == 3'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                acc_n = acc_step;
                if (acc_is_zero) begin
                    brw_n = 1'b1;
                end
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over every other transition; the result is discarded.
        if (flush) begin
            state_n = IDLE;
            acc_n   = 19'd0;
            cnt_n   = 3'd0;
            brw_n   = 1'b0;
        end
    end

    // Result fields read as zero unless a result is actually being offered.
    always_comb begin
        in_rdy    = (state == IDLE);
        out_val   = (state == DONE);
        out_o     = out_val ? acc : 19'd0;
        out_brw   = out_val & brw;
        out_zero  = out_val & acc_is_zero;
        dbg_state = state;
    end

endmodule

// File: doc/fu_gst_dec19.md
FU_GST_DEC19 -- requirements
Module: fu_gst_dec19

Interface
REQ-001 SHALL have no parameters; width is fixed at 19 bits, numbered [1:19] with bit 1 the MSB and bit 19 the LSB.
REQ-002 SHALL have port `nclk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_b`, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port `flush`, input, 1 bit: synchronous abort of any operation in progress.
REQ-005 SHALL have port `in_val`, input, 1 bit: operand valid.
REQ-006 SHALL have port `in_rdy`, output, 1 bit: block can accept an operand.
REQ-007 SHALL have port `in_a`, input, [1:19]: operand to decrement.
REQ-008 SHALL have port `in_k`, input, [0:2]: number of decrement steps, 0..7.
REQ-009 SHALL have port `out_val`, output, 1 bit: result valid.
REQ-010 SHALL have port `out_rdy`, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port `out_o`, output, [1:19]: result, in_a minus in_k.
REQ-012 SHALL have port `out_brw`, output, 1 bit: a borrow occurred, meaning a step was taken with the accumulator at 0.
REQ-013 SHALL have port `out_zero`, output, 1 bit: out_o equals 0.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, BUSY and DONE, plus registers acc[1:19], cnt[0:2] and a sticky brw bit.
REQ-015 SHALL drive in_rdy=1 only in IDLE and drive out_val=1 only in DONE.
REQ-016 SHALL, in IDLE when in_val=1, load acc=in_a, cnt=in_k and brw=0, then go to DONE if in_k=0, else go to BUSY.
REQ-017 SHALL, in BUSY, on each cycle: set acc=acc-1, set brw to 1 if acc was 0, set cnt=cnt-1, and go to DONE when cnt was 1.
REQ-018 SHALL therefore assert out_val exactly k+1 cycles after the accept edge, so k=0 gives 1 cycle and k=7 gives 8 cycles.
REQ-019 SHALL, in DONE, drive out_o=acc, out_brw=brw and out_zero=(acc==0), holding all of them stable while out_rdy=0.
REQ-020 SHALL, in DONE when out_rdy=1, return to IDLE, with in_rdy rising on the next cycle; there is no same-cycle accept from DONE.
REQ-021 SHALL force out_o, out_brw and out_zero to 0 whenever out_val=0.
REQ-022 SHALL, on flush=1 in any state, go to IDLE next cycle and clear acc, cnt and brw; flush has priority over in_val and out_rdy, and the result is dropped.
REQ-023 SHALL ignore in_a, in_k and in_val outside IDLE.
REQ-024 SHALL accept in_val=1 with in_rdy=0 as legal; no operand is captured.

Reset
REQ-025 SHALL, while rst_b=0, asynchronously set state to IDLE and acc, cnt and brw to 0.
REQ-026 SHALL hold outputs at reset as: in_rdy=1, out_val=0, out_o=0, out_brw=0, out_zero=0.
REQ-027 SHALL treat reset during BUSY or DONE as aborting the operation without emitting a result.
REQ-028 SHALL accept the first operand on the first rising edge of nclk after rst_b deasserts.

Configuration
REQ-029 SHALL, when macro FU_GST_DEC19_SAT_EN is defined, saturate a BUSY step with acc=0 so acc stays 0; brw is still set and cnt still counts down.
REQ-030 SHALL, when FU_GST_DEC19_SAT_EN is undefined, wrap a BUSY step with acc=0 to acc=0x7FFFF (modulo 2^19) and set brw=1.

Verification
REQ-031 SHALL cover: in_a=0x00005, k=3, out_rdy=1 -> out_val 4 cycles after accept, out_o=0x00002, out_brw=0, out_zero=0.
REQ-032 SHALL cover: in_a=0x00001, k=2 -> out_o=0x7FFFF and out_brw=1 without the macro; out_o=0x00000, out_brw=1, out_zero=1 with FU_GST_DEC19_SAT_EN.
REQ-033 SHALL cover: in_a=0x12345, k=0 -> out_val 1 cycle after accept, out_o=0x12345, out_brw=0.
REQ-034 SHALL cover: in_a=0x00010, k=7, out_rdy=0 for 5 cycles -> out_o=0x00009 stable and in_rdy=0 throughout; out_rdy=1 -> IDLE, in_rdy=1 on the next cycle.
REQ-035 SHALL cover: flush=1 on the 2nd BUSY cycle -> out_val never asserts, in_rdy=1 on the next cycle, and the next operand is computed correctly.
REQ-036 SHALL cover: rst_b=0 asserted mid-BUSY without a clock edge -> outputs immediately take the reset values; after release, in_a=0x40000, k=1 -> out_o=0x3FFFF.
